// File: rtl/mem_access_pkg.sv
// Shared types and default geometry for the load/store front end of the
// 128-bit x 32-line data memory.
package mem_access_pkg;

  localparam int DEF_LINES      = 32;
  localparam int DEF_LINE_W     = 128;
  localparam int LINE_BYTES     = DEF_LINE_W / 8;
  localparam int WORDS_PER_LINE = DEF_LINE_W / 32;
  localparam int BOFF_W         = 2;
  localparam int WOFF_W         = $clog2(WORDS_PER_LINE);
  localparam int LIDX_W         = $clog2(DEF_LINES);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/mem_lane_merge.sv
// Combinational lane logic: merges store data into a line and extracts
// sign/zero-extended load data from a line.
module mem_lane_merge
  import mem_access_pkg::*;
#(
  parameter int LINE_W    = DEF_LINE_W,
  parameter int WOFF_BITS = WOFF_W
) (
  input  logic [LINE_W-1:0]    line_data,
  input  logic [WOFF_BITS-1:0] woff,
  input  logic [1:0]           boff,
  input  size_e                size,
  input  logic [31:0]          wdata,
  input  logic                 is_signed,
  output logic [LINE_W-1:0]    merged,
  output logic [31:0]          loaded
);

  function automatic logic [LINE_W-1:0] merge_line(
    input logic [LINE_W-1:0]    l,
    input logic [WOFF_BITS-1:0] w,
    input logic [1:0]           b,
    input size_e                s,
    input logic [31:0]          d
  );
    logic [31:0]       word;
    logic [LINE_W-1:0] res;
    word = l[w*32 +: 32];
    case (s)
      SZ_BYTE: word[b*8 +: 8]     = d[7:0];
      SZ_HALF: word[b[1]*16 +: 16] = d[15:0];
      default: word               = d;
    endcase
    res            = l;
    res[w*32 +: 32] = word;
    return res;
  endfunction

  function automatic logic [31:0] extract_word(
    input logic [LINE_W-1:0]    l,
    input logic [WOFF_BITS-1:0] w,
    input logic [1:0]           b,
    input size_e                s,
    input logic                 sg
  );
    logic [31:0] word;
    logic [7:0]  bv;
    logic [15:0] hv;
    logic [31:0] res;
    word = l[w*32 +: 32];
    bv   = word[b*8 +: 8];
    hv   = word[b[1]*16 +: 16];
    case (s)
      SZ_BYTE: res = {{24{sg & bv[7]}}, bv};
      SZ_HALF: res = {{16{sg & hv[15]}}, hv};
      default: res = word;
    endcase
    return res;
  endfunction

  assign merged = merge_line(line_data, woff, boff, size, wdata);
  assign loaded = extract_word(line_data, woff, boff, size, is_signed);

endmodule

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store unit over a line-wide memory, stores done as RMW.
// Optional MEM_ACCESS_MISALIGN_TRAP_EN: misaligned half/word return resp_err.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int LINES  = DEF_LINES,
  parameter int LINE_W = DEF_LINE_W,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_signed,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_rdata,
  output logic                     resp_err,
  output logic                     mem_we,
  output logic [$clog2(LINES)-1:0] mem_addr,
  output logic [LINE_W-1:0]        mem_wdata,
  input  logic [LINE_W-1:0]        mem_rdata,
  output logic [1:0]               dbg_state
);

  localparam int IDX_BITS  = $clog2(LINES);
  localparam int WOFF_LO   = $clog2(LINE_W / 32);
  localparam int WOFF_BITS = (WOFF_LO > 0) ? WOFF_LO : 1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; the side raising valid holds its payload until that edge.
  state_e                state;
  logic                  r_we;
  size_e                 r_size;
  logic                  r_signed;
  logic                  r_err;
  logic [1:0]            r_boff;
  logic [WOFF_BITS-1:0]  r_woff;
  logic [IDX_BITS-1:0]   r_lidx;
  logic [31:0]           r_wdata;
  logic [LINE_W-1:0]     line_q;

  size_e                 size_in;
  logic [1:0]            boff_in;
  logic [WOFF_BITS-1:0]  woff_in;
  logic                  misalign;
  logic [LINE_W-1:0]     merged;
  logic [31:0]           loaded;
  logic                  unused_addr;

  assign unused_addr = ^req_addr;
  assign woff_in     = (WOFF_LO > 0) ? req_addr[2 +: WOFF_BITS] : '0;

  always_comb begin
    case (req_size)
      2'd0:    size_in = SZ_BYTE;
      2'd1:    size_in = SZ_HALF;
      default: size_in = SZ_WORD;
    endcase
    boff_in  = req_addr[1:0];
    misalign = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    misalign = ((size_in == SZ_HALF) && req_addr[0]) ||
               ((size_in == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    if (size_in == SZ_HALF)      boff_in[0] = 1'b0;
    else if (size_in == SZ_WORD) boff_in    = 2'b00;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      r_we     <= 1'b0;
      r_size   <= SZ_BYTE;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
      r_boff   <= '0;
      r_woff   <= '0;
      r_lidx   <= '0;
      r_wdata  <= '0;
      line_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (req_valid) begin
          r_we     <= req_we;
          r_size   <= size_in;
          r_signed <= req_signed;
          r_err    <= misalign;
          r_boff   <= boff_in;
          r_woff   <= woff_in;
          r_lidx   <= req_addr[2+WOFF_LO +: IDX_BITS];
          r_wdata  <= req_wdata;
          state    <= misalign ? ST_RESP : ST_RD;
        end
        ST_RD: begin
          line_q <= mem_rdata;
          state  <= r_we ? ST_WR : ST_RESP;
        end
        ST_WR:   state <= ST_RESP;
        ST_RESP: if (resp_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  mem_lane_merge #(
    .LINE_W    (LINE_W),
    .WOFF_BITS (WOFF_BITS)
  ) u_lane (
    .line_data (line_q),
    .woff      (r_woff),
    .boff      (r_boff),
    .size      (r_size),
    .wdata     (r_wdata),
    .is_signed (r_signed),
    .merged    (merged),
    .loaded    (loaded)
  );

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_err   = resp_valid & r_err;
  // Stores and trapped accesses answer with zero data.
  assign resp_rdata = (resp_valid && !r_we && !r_err) ? loaded : 32'd0;
  assign mem_we     = (state == ST_WR);
  assign mem_addr   = ((state == ST_RD) || (state == ST_WR)) ? r_lidx : '0;
  assign mem_wdata  = mem_we ? merged : '0;
  assign dbg_state  = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a byte-level reference memory.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int LINES  = 32;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'd0;
  logic              req_signed = 1'b0;
  logic [31:0]       req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_ready = 1'b0;
  logic              req_ready;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_we;
  logic [4:0]        mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic [1:0]        dbg_state;

  logic [LINE_W-1:0] mem [LINES];
  logic [LINE_W-1:0] ref_mem [LINES];
  logic              pl_en = 1'b0;
  logic [4:0]        pl_idx = '0;
  logic [LINE_W-1:0] pl_data = '0;

  logic [32:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int we_count = 0;
  int we_base = 0;
  int exp_lat = 0;
  int exp_pulses = 0;
  int exp_line = 0;
  logic [4:0] we_addr_last = '0;

  mem_access_unit #(.LINES(LINES), .LINE_W(LINE_W), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .dbg_state  (dbg_state)
  );

  // clock / memory model
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (pl_en) mem[pl_idx] <= pl_data;
  end

  always @(negedge clk) begin
    if (mem_we) begin
      we_count     <= we_count + 1;
      we_addr_last <= mem_addr;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [LINE_W-1:0] data);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_idx  = idx[4:0];
    pl_data = data;
    @(negedge clk);
    pl_en        = 1'b0;
    ref_mem[idx] = data;
  endtask

  // Model the access, queue the expected response, then drive the request.
  task automatic send(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] addr, input logic [31:0] wd, input bit lost);
    int line, wi, bo, nb, n;
    bit err;
    logic [31:0] rd;
    line = int'(addr[8:4]);
    wi   = int'(addr[3:2]);
    bo   = int'(addr[1:0]);
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err  = 1'b0;
    rd   = '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    err = ((bo % nb) != 0);
`else
    bo = bo - (bo % nb);
`endif
    if (!err) begin
      for (int k = 0; k < nb; k++) begin
        if (we) begin
          if (!lost) ref_mem[line][8*(4*wi+bo+k) +: 8] = wd[8*k +: 8];
        end else begin
          rd[8*k +: 8] = ref_mem[line][8*(4*wi+bo+k) +: 8];
        end
      end
      if (!we && sg && nb < 4)
        for (int k = 8*nb; k < 32; k++) rd[k] = rd[8*nb-1];
    end
    exp_lat    = err ? 1 : (we ? 3 : 2);
    exp_pulses = (err || !we) ? 0 : 1;
    exp_line   = line;
    we_base    = we_count;
    if (!lost) exp_q.push_back({err, rd});

    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_accept", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic get_resp(input int hold);
    int n;
    logic [32:0] e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 20);
    check("resp_seen", resp_valid, 1'b1);
    check("latency", n, exp_lat);
    check("sb_pending", exp_q.size() > 0, 1'b1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", resp_valid, 1'b1);
      check("hold_rdata", resp_rdata, e[31:0]);
      check("hold_req_ready", req_ready, 1'b0);
      check("hold_state", dbg_state, ST_RESP);
      @(negedge clk);
    end
    check("rdata", resp_rdata, e[31:0]);
    check("err", resp_err, e[32]);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check("we_pulses", we_count - we_base, exp_pulses);
    if (exp_pulses != 0) begin
      check("we_line", we_addr_last, exp_line);
      check("mem_line", mem[exp_line], ref_mem[exp_line]);
    end
  endtask

  initial begin
    logic [LINE_W-1:0] tmp;
    int n;

    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 5'd0);
    check("rst_mem_wdata", mem_wdata, 128'd0);
    check("rst_state", dbg_state, ST_IDLE);

    for (int i = 0; i < LINES; i++)
      preload(i, {$urandom(), $urandom(), $urandom(), $urandom()});
    @(negedge clk);
    rst_n = 1'b1;

    // word store then load back
    send(1'b1, 2'd2, 1'b0, 32'h0000_0014, 32'hDEAD_BEEF, 1'b0);
    get_resp(0);
    check("st_word_lane", mem[1][63:32], 32'hDEAD_BEEF);
    send(1'b0, 2'd2, 1'b0, 32'h0000_0014, 32'd0, 1'b0);
    get_resp(0);

    // signed / unsigned byte load
    tmp = ref_mem[0];
    tmp[31:0] = 32'h0000_0080;
    preload(0, tmp);
    send(1'b0, 2'd0, 1'b1, 32'h0, 32'd0, 1'b0);
    get_resp(0);
    send(1'b0, 2'd0, 1'b0, 32'h0, 32'd0, 1'b0);
    get_resp(0);

    // half store read-modify-write
    preload(2, {4{32'h1111_1111}});
    send(1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'h0000_ABCD, 1'b0);
    get_resp(0);
    check("half_rmw_line", mem[2], 128'h11111111_11111111_11111111_ABCD1111);

    // backpressure with a competing request held on the bus
    send(1'b0, 2'd2, 1'b0, 32'h0000_0014, 32'd0, 1'b0);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 2'd1;
    req_addr  = 32'h0000_0022;
    get_resp(5);
    send(1'b0, 2'd1, 1'b1, 32'h0000_0022, 32'd0, 1'b0);
    get_resp(0);

    // misaligned word load and store
    send(1'b0, 2'd2, 1'b0, 32'h0000_0003, 32'd0, 1'b0);
    get_resp(0);
    send(1'b1, 2'd2, 1'b0, 32'h0000_0007, 32'h1234_5678, 1'b0);
    get_resp(0);

    // reset during the write cycle of a store
    send(1'b1, 2'd2, 1'b0, 32'h0000_0044, 32'hCAFE_F00D, 1'b1);
    n = 0;
    while (!mem_we && n < 5) begin
      @(negedge clk);
      n++;
    end
    check("rst_wr_seen", mem_we, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_we_drop", mem_we, 1'b0);
    check("rst_mid_state", dbg_state, ST_IDLE);
    check("rst_mid_resp", resp_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel_ready", req_ready, 1'b1);
    check("rst_line_kept", mem[4], ref_mem[4]);

    // random mix, addresses wrap through the upper bits
    for (int i = 0; i < 40; i++) begin
      send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           $urandom(), $urandom(), 1'b0);
      get_resp($urandom_range(0, 2));
    end

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front end sitting directly upstream of the 128-bit x 32-line data memory.
- Accepts 32-bit byte-addressed CPU loads and stores (byte/half/word) over a valid/ready handshake.
- Converts them into line-wide memory accesses; sub-line stores are done as read-modify-write.
- Returns load data sign- or zero-extended, with a completion response for every request.

Parameters:
- LINES, 32, number of memory lines; line index width is $clog2(LINES).
- LINE_W, 128, line width in bits; must be a multiple of 32.
- ADDR_W, 32, CPU byte-address width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word).
- req_signed  in  1  sign-extend load result.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response available.
- resp_ready  in  1  CPU accepts response.
- resp_rdata  out  32  load result; 0 for stores.
- resp_err  out  1  misaligned access (feature-dependent).
- mem_we  out  1  line write enable.
- mem_addr  out  $clog2(LINES)  line index.
- mem_wdata  out  LINE_W  merged line.
- mem_rdata  in  LINE_W  line read data, valid one cycle after mem_addr is presented.

Behaviour:
- Address split:
  - byte offset = addr[1:0]
  - word offset = addr[$clog2(LINE_W/8)-1:2]
  - line index = next $clog2(LINES) bits
  - upper bits ignored, so addresses wrap modulo LINES*LINE_W/8.
- FSM states: IDLE, RD, WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture we/size/signed/addr/wdata into request registers, drive mem_addr from the captured index, go to RD.
- RD:
  - One wait cycle; mem_rdata is sampled at the end of RD into a line register.
  - Load: go to RESP.
  - Store: go to WR.
- WR:
  - mem_we=1 for exactly one cycle.
  - mem_wdata = captured line with the selected bytes replaced:
    - byte: 1 lane
    - half: 2 lanes at addr[1]
    - word: 4 lanes
  - Go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until resp_ready.
  - On resp_ready, go to IDLE. No new request is accepted in the same cycle.
- Load extraction:
  - Select the 32-bit word by word offset, then the byte or half by addr[1:0].
  - Extend to 32 bits: sign-extend if req_signed, else zero-extend. Word loads ignore req_signed.
- Latency:
  - Load: accept to resp_valid = 2 cycles.
  - Store: accept to resp_valid = 3 cycles.
  - Throughput: one request per 3 (load) / 4 (store) cycles when resp_ready is tied high.
- mem_addr holds the captured index from RD through WR; outside RD/WR it is 0.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset asserted mid-operation: state returns to IDLE asynchronously, mem_we drops immediately, and any pending store is lost. A partial line write is impossible because the write takes one cycle.
- req_valid while busy: ignored (req_ready=0). The CPU must hold the request.

Optional Feature:
- Macro MEM_ACCESS_MISALIGN_TRAP_EN.
- Defined: a half with addr[0]=1 or a word with addr[1:0]!=0 skips RD/WR and goes IDLE->RESP next cycle with resp_err=1, resp_rdata=0, and no memory write.
- Undefined: low bits are forced to alignment (half: addr[0]=0, word: addr[1:0]=0), the access proceeds normally, and resp_err is tied 0.

Decomposition:
- mem_access_pkg holds:
  - the size_e enum (SZ_BYTE, SZ_HALF, SZ_WORD)
  - the state_e enum
  - LINE_BYTES / WORDS_PER_LINE constants
  - the offset-width localparams.
- Sub-module mem_lane_merge: purely combinational, two functions:
  - given line, offsets, size and wdata, produces the merged line;
  - given line, offsets, size and signed, produces the extracted 32-bit result.
- The FSM stays in mem_access_unit.

Test Plan:
- Word store then load: store 0xDEADBEEF at 0x0000_0014, then load word at 0x14 -> mem_we pulse at line 1 with bits[63:32]=0xDEADBEEF, other lanes unchanged; load resp_rdata=0xDEADBEEF, 2-cycle latency.
- Signed byte load: line 0 word 0 = 0x0000_0080, load byte at 0x0 -> signed gives 0xFFFF_FF80, unsigned gives 0x0000_0080.
- Half store RMW: line 2 preloaded 0x1111..., store half 0xABCD at 0x22 -> line 2 bits[31:16]=0xABCD, all other bits still 0x1...
- Backpressure: resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0, and a new req_valid is not accepted until after resp_ready.
- Reset mid-store: assert rst_n=0 during WR -> mem_we=0 immediately, state IDLE, req_ready=1 after release.
- Misaligned word at 0x3:
  - with MEM_ACCESS_MISALIGN_TRAP_EN: resp_err=1, no mem_we;
  - without it: access goes to 0x0 and resp_err=0.
